// File: rtl/smp_snoop_bus_arbiter.sv
// Snooping bus controller shared by two MSI caches and unified memory.
// Ports: req/kind/addr per core in, done per core out, bus_op/bus_addr broadcast, snoop flush in, mem rd/wr out.
module smp_snoop_bus_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic [1:0]        kind0,
  input  logic [1:0]        kind1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  output logic              done0,
  output logic              done1,
  output logic [DATA_W-1:0] rdata,
  output logic [2:0]        bus_op,
  output logic [ADDR_W-1:0] bus_addr,
  input  logic              snp_flush,
  input  logic [DATA_W-1:0] snp_data,
  output logic              busy,
  output logic              mem_re,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SNOOP,
    S_WB,
    S_MEM,
    S_DONE
  } state_t;

  typedef enum logic [2:0] {
    NOOP = 3'd0,
    RD0  = 3'd1,
    RD1  = 3'd2,
    WR0  = 3'd3,
    WR1  = 3'd4,
    INV0 = 3'd5,
    INV1 = 3'd6
  } bus_op_t;

  state_t      state, state_n;
  bus_op_t     op;
  logic        win, win_n;
  logic        last_gnt;
  logic [1:0]  kind_q;
  logic [CW-1:0] cnt;
  logic        gnt;
  logic        ld_cnt, dec_cnt;
  logic        cap_snp, cap_mem;
  logic        inv_k, wr_k;

  // Tie goes to the core that did not win last time.
  assign win_n = (req0 & req1) ? ~last_gnt : req1;

  assign inv_k = (kind_q == 2'b10);
  assign wr_k  = (kind_q == 2'b01);
  assign bus_op = op;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n  = state;
    op       = NOOP;
    gnt      = 1'b0;
    busy     = 1'b1;
    mem_re   = 1'b0;
    mem_we   = 1'b0;
    mem_addr = '0;
    done0    = 1'b0;
    done1    = 1'b0;
    ld_cnt   = 1'b0;
    dec_cnt  = 1'b0;
    cap_snp  = 1'b0;
    cap_mem  = 1'b0;
    unique case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (req0 | req1) begin
          gnt     = 1'b1;
          state_n = S_SNOOP;
        end
      end
      S_SNOOP: begin
        unique case (1'b1)
          inv_k:   op = win ? INV1 : INV0;
          wr_k:    op = win ? WR1 : WR0;
          default: op = win ? RD1 : RD0;
        endcase
        if (inv_k) begin
          state_n = S_DONE;
        end else if (snp_flush) begin
          cap_snp = 1'b1;
          state_n = S_WB;
        end else begin
          ld_cnt  = 1'b1;
          state_n = S_MEM;
        end
      end
      S_WB: begin
        mem_we   = 1'b1;
        mem_addr = bus_addr;
        state_n  = S_DONE;
      end
      S_MEM: begin
        mem_re   = 1'b1;
        mem_addr = bus_addr;
        if (cnt == '0) begin
          cap_mem = 1'b1;
          state_n = S_DONE;
        end else begin
          dec_cnt = 1'b1;
        end
      end
      S_DONE: begin
        done0   = ~win;
        done1   = win;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win       <= 1'b0;
      last_gnt  <= 1'b1;
      kind_q    <= 2'b00;
      bus_addr  <= '0;
      cnt       <= '0;
      rdata     <= '0;
      mem_wdata <= '0;
    end else begin
      if (gnt) begin
        win      <= win_n;
        last_gnt <= win_n;
        kind_q   <= win_n ? kind1 : kind0;
        bus_addr <= win_n ? addr1 : addr0;
      end
      if (ld_cnt)  cnt <= CW'(MEM_LAT - 1);
      if (dec_cnt) cnt <= cnt - 1'b1;
      if (cap_snp) begin
        rdata     <= snp_data;
        mem_wdata <= snp_data;
      end
      if (cap_mem) rdata <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_smp_snoop_bus_arbiter.sv
// Randomized bench for smp_snoop_bus_arbiter.
// Transaction-level model predicts winner, bus op, latency and fill data.
module tb_smp_snoop_bus_arbiter;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0, req1;
  logic [1:0]  kind0, kind1;
  logic [15:0] addr0, addr1;
  logic        done0, done1;
  logic [15:0] rdata;
  logic [2:0]  bus_op;
  logic [15:0] bus_addr;
  logic        snp_flush;
  logic [15:0] snp_data;
  logic        busy, mem_re, mem_we;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;

  int n_chk = 0;
  int n_fail = 0;

  bit          pend [2];
  logic [1:0]  kind_m [2];
  logic [15:0] addr_m [2];
  int          last;
  logic [15:0] exp_rd;

  smp_snoop_bus_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1),
    .kind0(kind0), .kind1(kind1),
    .addr0(addr0), .addr1(addr1),
    .done0(done0), .done1(done1),
    .rdata(rdata), .bus_op(bus_op), .bus_addr(bus_addr),
    .snp_flush(snp_flush), .snp_data(snp_data),
    .busy(busy), .mem_re(mem_re), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic post_req(input int core, input logic [1:0] k,
                          input logic [15:0] a);
    pend[core]   = 1'b1;
    kind_m[core] = k;
    addr_m[core] = a;
    if (core == 0) begin
      req0 = 1'b1; kind0 = k; addr0 = a;
    end else begin
      req1 = 1'b1; kind1 = k; addr1 = a;
    end
  endtask

  // Called at the falling edge of an idle cycle with at least one request up.
  task automatic run_txn(input bit fl, input logic [15:0] sd,
                         input logic [15:0] md);
    int w, lat, re_n, we_n, op_n;
    bit inv, wr, mem, got;
    logic [2:0] eop;
    logic [15:0] a;
    w = (pend[0] && pend[1]) ? (1 - last) : (pend[1] ? 1 : 0);
    last = w;
    inv = (kind_m[w] == 2'b10);
    wr  = (kind_m[w] == 2'b01);
    eop = inv ? 3'(5 + w) : wr ? 3'(3 + w) : 3'(1 + w);
    mem = !inv && !fl;
    lat = inv ? 2 : (fl ? 3 : 2 + LAT);
    a = addr_m[w];
    if (!inv) exp_rd = fl ? sd : md;
    snp_flush = fl;
    snp_data  = sd;
    mem_rdata = ~md;
    got = 0; re_n = 0; we_n = 0; op_n = 0;
    for (int c = 1; c <= 20 && !got; c++) begin
      @(negedge clk);
      if (c == 1) begin
        check("snoop_op", bus_op, eop);
        check("bus_addr", bus_addr, a);
        if (w == 0) begin
          addr0 = 16'($urandom); kind0 = 2'($urandom);
        end else begin
          addr1 = 16'($urandom); kind1 = 2'($urandom);
        end
      end
      if (bus_op != 3'd0) op_n++;
      if (mem_re) begin
        re_n++;
        check("re_addr", mem_addr, a);
        mem_rdata = (re_n == LAT) ? md : ~md;
      end
      if (mem_we) begin
        we_n++;
        check("we_addr", mem_addr, a);
        check("we_data", mem_wdata, sd);
      end
      if (done0 | done1) begin
        got = 1;
        check("done_lat", c, lat);
        check("done_who", {done1, done0}, (w == 1) ? 2 : 1);
        check("rdata", rdata, exp_rd);
        pend[w] = 1'b0;
        if (w == 0) req0 = 1'b0;
        else        req1 = 1'b0;
      end
    end
    check("done_seen", got, 1);
    check("op_cycles", op_n, 1);
    check("re_cycles", re_n, mem ? LAT : 0);
    check("we_cycles", we_n, (fl && !inv) ? 1 : 0);
    @(negedge clk);
    check("idle_busy", busy, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    req0 = 0; req1 = 0; kind0 = 0; kind1 = 0; addr0 = 0; addr1 = 0;
    snp_flush = 0; snp_data = 0; mem_rdata = 0;
    pend[0] = 0; pend[1] = 0; last = 1; exp_rd = '0;
    #1;
    check("rst_op", bus_op, 0);
    check("rst_busy", busy, 0);
    check("rst_done", {done1, done0}, 0);
    check("rst_mem", {mem_re, mem_we}, 0);
    check("rst_rdata", rdata, 0);
    check("rst_maddr", mem_addr, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Tie from reset: core0 first, then core1; then again core0 first.
    post_req(0, 2'b00, 16'h0123);
    post_req(1, 2'b00, 16'h0200);
    run_txn(0, 16'h0000, 16'hBEEF);
    run_txn(0, 16'h0000, 16'hCAFE);
    post_req(0, 2'b11, 16'h0300);
    post_req(1, 2'b01, 16'h0400);
    run_txn(0, 16'h0000, 16'h1111);
    run_txn(1, 16'h2222, 16'h3333);

    // Core1 write miss with flush, then core0 invalidate with flush.
    post_req(1, 2'b01, 16'h0040);
    run_txn(1, 16'h1234, 16'h9999);
    post_req(0, 2'b10, 16'h0050);
    run_txn(1, 16'h7777, 16'h8888);

    for (int i = 0; i < 60; i++) begin
      for (int k = 0; k < 2; k++)
        if (!pend[k] && $urandom_range(1, 0) == 1)
          post_req(k, 2'($urandom), 16'($urandom));
      if (!pend[0] && !pend[1])
        post_req(int'($urandom_range(1, 0)), 2'($urandom), 16'($urandom));
      run_txn(1'($urandom), 16'($urandom), 16'($urandom));
    end
    while (pend[0] || pend[1])
      run_txn(1'($urandom), 16'($urandom), 16'($urandom));

    // Reset while a core0 read sits in memory.
    post_req(0, 2'b00, 16'h0ABC);
    snp_flush = 1'b0;
    for (int c = 0; c < 10 && !mem_re; c++) @(negedge clk);
    check("reach_mem", mem_re, 1);
    #1 rst_n = 1'b0;
    #1;
    check("mrst_op", bus_op, 0);
    check("mrst_busy", busy, 0);
    check("mrst_mem", {mem_re, mem_we}, 0);
    check("mrst_done", {done1, done0}, 0);
    req0 = 1'b0; pend[0] = 0;
    last = 1; exp_rd = '0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("mrst_nodone", {done1, done0}, 0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_rdata", rdata, 0);
    post_req(1, 2'b00, 16'h0777);
    run_txn(0, 16'h0000, 16'h5A5A);
    post_req(0, 2'b00, 16'h0888);
    post_req(1, 2'b00, 16'h0999);
    run_txn(0, 16'h0000, 16'h6B6B);
    run_txn(0, 16'h0000, 16'h7C7C);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
